// File: rtl/fifo_tx_scheduler.sv
// Round-robin TX scheduler framing ADC samples and status messages onto the single-byte fifo_interface port.
// Optional: define FIFO_TX_SCHED_MSG_PRIO_EN to give the message channel strict priority over samples.
module fifo_tx_scheduler #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  MSG_TAG     = 8'h5A,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        smp_valid_i,
  input  logic [15:0] smp_data_i,
  output logic        smp_ready_o,
  input  logic        msg_valid_i,
  input  logic [7:0]  msg_data_i,
  output logic        msg_ready_o,
  output logic        tx_data_rdy_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ok_i,
  input  logic        tx_err_i,
  input  logic        busy_i,
  output logic        frame_done_o,
  output logic        frame_drop_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ADVANCE, S_RETRY, S_DROP
  } state_t;

  state_t          state, next_state;
  logic [3:0][7:0] frame_buf;
  logic            is_msg;
  logic [1:0]      idx;
  logic [1:0]      last_idx;
  logic [3:0]      retry;
  logic [15:0]     timer;
  logic [7:0]      drop_cnt;
  logic            grant_smp, grant_msg;
  logic            retry_left;

`ifdef FIFO_TX_SCHED_MSG_PRIO_EN
  assign grant_msg = msg_valid_i;
  assign grant_smp = smp_valid_i & ~msg_valid_i;
`else
  logic prefer_msg;
  assign grant_msg = msg_valid_i & (~smp_valid_i | prefer_msg);
  assign grant_smp = smp_valid_i & (~msg_valid_i | ~prefer_msg);
`endif

  assign last_idx   = is_msg ? 2'd1 : 2'd2;
  assign retry_left = 32'(retry) < MAX_RETRY;
  assign drop_cnt_o = drop_cnt;

  // Ready is gated by reset so that all outputs read 0 while reset is held.
  assign smp_ready_o = (state == S_IDLE) & grant_smp & reset_ni;
  assign msg_ready_o = (state == S_IDLE) & grant_msg & reset_ni;

  always_comb begin
    next_state    = state;
    tx_data_rdy_o = 1'b0;
    tx_data_o     = '0;
    frame_done_o  = 1'b0;
    frame_drop_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_smp | grant_msg) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        tx_data_o = frame_buf[idx];
        if (!busy_i) begin
          tx_data_rdy_o = 1'b1;
          next_state    = S_WAIT;
        end
      end
      S_WAIT: begin
        tx_data_o = frame_buf[idx];
        if (tx_ok_i)                                      next_state = S_ADVANCE;
        else if (tx_err_i || timer == 16'(ACK_TIMEOUT))   next_state = S_RETRY;
      end
      S_ADVANCE: begin
        if (idx == last_idx) begin
          frame_done_o = 1'b1;
          next_state   = S_IDLE;
        end else begin
          next_state   = S_ISSUE;
        end
      end
      S_RETRY: begin
        next_state = retry_left ? S_ISSUE : S_DROP;
      end
      S_DROP: begin
        frame_drop_o = 1'b1;
        next_state   = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= S_IDLE;
      frame_buf <= '0;
      is_msg    <= 1'b0;
      idx       <= '0;
      retry     <= '0;
      timer     <= '0;
      drop_cnt  <= '0;
`ifndef FIFO_TX_SCHED_MSG_PRIO_EN
      prefer_msg <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (grant_smp) begin
            frame_buf <= {8'h00, smp_data_i[7:0], smp_data_i[15:8], SYNC_BYTE};
            is_msg    <= 1'b0;
            idx       <= '0;
            retry     <= '0;
`ifndef FIFO_TX_SCHED_MSG_PRIO_EN
            prefer_msg <= 1'b1;
`endif
          end else if (grant_msg) begin
            frame_buf <= {8'h00, 8'h00, msg_data_i, MSG_TAG};
            is_msg    <= 1'b1;
            idx       <= '0;
            retry     <= '0;
`ifndef FIFO_TX_SCHED_MSG_PRIO_EN
            prefer_msg <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (!busy_i) timer <= '0;
        end
        S_WAIT: begin
          timer <= timer + 16'd1;
        end
        S_ADVANCE: begin
          if (idx != last_idx) begin
            idx   <= idx + 2'd1;
            retry <= '0;
          end
        end
        S_RETRY: begin
          if (retry_left) retry <= retry + 4'd1;
        end
        S_DROP: begin
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Directed self-checking bench for fifo_tx_scheduler; a responder process plays fifo_interface.
// Honours FIFO_TX_SCHED_MSG_PRIO_EN when computing the expected arbitration order.
module tb_fifo_tx_scheduler;

  localparam int ACK_TO = 8;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        smp_valid_i = 1'b0;
  logic [15:0] smp_data_i = '0;
  logic        smp_ready_o;
  logic        msg_valid_i = 1'b0;
  logic [7:0]  msg_data_i = '0;
  logic        msg_ready_o;
  logic        tx_data_rdy_o;
  logic [7:0]  tx_data_o;
  logic        tx_ok_i = 1'b0;
  logic        tx_err_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        frame_done_o;
  logic        frame_drop_o;
  logic [7:0]  drop_cnt_o;

  always #5 clk = ~clk;

  fifo_tx_scheduler #(
    .SYNC_BYTE  (8'hA5),
    .MSG_TAG    (8'h5A),
    .MAX_RETRY  (3),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .smp_valid_i  (smp_valid_i),
    .smp_data_i   (smp_data_i),
    .smp_ready_o  (smp_ready_o),
    .msg_valid_i  (msg_valid_i),
    .msg_data_i   (msg_data_i),
    .msg_ready_o  (msg_ready_o),
    .tx_data_rdy_o(tx_data_rdy_o),
    .tx_data_o    (tx_data_o),
    .tx_ok_i      (tx_ok_i),
    .tx_err_i     (tx_err_i),
    .busy_i       (busy_i),
    .frame_done_o (frame_done_o),
    .frame_drop_o (frame_drop_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration (written only by the stimulus process).
  int         resp_mode = 0;   // 0 ok, 1 err on err_byte up to err_limit, 2 always err, 3 silent
  logic [7:0] err_byte  = '0;
  int         err_limit = 0;

  // Monitor/responder state (written only by the responder process).
  int         cyc = 0;
  int         done_seen = 0, drop_seen = 0, smp_rdy_seen = 0, msg_rdy_seen = 0;
  int         busy_viol = 0, smp_rdy_cyc = 0, errs_total = 0;
  bit         ack_pending = 1'b0;
  logic [7:0] cur_byte = '0;
  logic [7:0] strobe_q[$];
  int         strobe_t[$];

  always begin
    @(negedge clk);
    cyc++;
    if (smp_ready_o) begin smp_rdy_seen++; smp_rdy_cyc = cyc; end
    if (msg_ready_o) msg_rdy_seen++;
    if (frame_done_o) done_seen++;
    if (frame_drop_o) drop_seen++;
    if (tx_data_rdy_o) begin
      strobe_q.push_back(tx_data_o);
      strobe_t.push_back(cyc);
      if (busy_i) busy_viol++;
      ack_pending = 1'b1;
      cur_byte    = tx_data_o;
    end
    @(posedge clk); #1;
    tx_ok_i  = 1'b0;
    tx_err_i = 1'b0;
    if (ack_pending) begin
      ack_pending = 1'b0;
      case (resp_mode)
        0: tx_ok_i = 1'b1;
        1: if (cur_byte == err_byte && errs_total < err_limit) begin
             tx_err_i = 1'b1;
             errs_total++;
           end else tx_ok_i = 1'b1;
        2: tx_err_i = 1'b1;
        default: ;
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_ni = 1'b1;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_seen + drop_seen >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_sample(input logic [15:0] d);
    @(posedge clk); #1;
    smp_data_i  = d;
    smp_valid_i = 1'b1;
    @(posedge clk); #1;
    smp_valid_i = 1'b0;
    smp_data_i  = 16'hFFFF;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o, smp_ready_o, msg_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%b required all zero", {tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o});
    end
    reset_ni = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o, smp_ready_o, msg_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%b required all zero", {tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o});
    end
  endtask

  task automatic test_single_sample();
    logic [7:0] exp[$] = '{8'hA5, 8'h12, 8'h34};
    int bs = strobe_q.size(), bd = done_seen, br = smp_rdy_seen, bdr = drop_seen;
    bit ok;
    @(posedge clk); #1;
    smp_data_i  = 16'h1234;
    smp_valid_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (smp_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", smp_ready_o); end
    @(posedge clk); #1;
    smp_valid_i = 1'b0;
    smp_data_i  = 16'hFFFF;
    wait_frames(bd + bdr + 1, 100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: frame not finished got 0 required 1"); end
    n_tests++;
    if (strobe_q.size() - bs !== exp.size()) begin
      n_fail++; $display("FAIL single_count: got %0d strobes required %0d", strobe_q.size() - bs, exp.size());
    end
    for (int i = 0; i < exp.size() && bs + i < strobe_q.size(); i++) begin
      n_tests++;
      if (strobe_q[bs+i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h required %h", i, strobe_q[bs+i], exp[i]); end
    end
    n_tests++;
    if (done_seen - bd !== 1 || drop_seen - bdr !== 0) begin
      n_fail++; $display("FAIL single_pulses: done %0d drop %0d required 1 0", done_seen - bd, drop_seen - bdr);
    end
    n_tests++;
    if (smp_rdy_seen - br !== 1) begin n_fail++; $display("FAIL single_ready_cycles: got %0d required 1", smp_rdy_seen - br); end
    if (bs < strobe_t.size()) begin
      n_tests++;
      if (strobe_t[bs] - smp_rdy_cyc !== 1) begin
        n_fail++; $display("FAIL single_latency: got %0d required 1", strobe_t[bs] - smp_rdy_cyc);
      end
    end
  endtask

  task automatic test_round_robin();
`ifdef FIFO_TX_SCHED_MSG_PRIO_EN
    logic [7:0] exp[$] = '{8'h5A, 8'h42, 8'h5A, 8'h42, 8'h5A, 8'h42};
`else
    logic [7:0] exp[$] = '{8'hA5, 8'hBE, 8'hEF, 8'h5A, 8'h42, 8'hA5, 8'hBE, 8'hEF};
`endif
    int bs, bd, bdr;
    bit ok;
    do_reset();
    bs = strobe_q.size(); bd = done_seen; bdr = drop_seen;
    @(posedge clk); #1;
    smp_data_i  = 16'hBEEF;
    msg_data_i  = 8'h42;
    smp_valid_i = 1'b1;
    msg_valid_i = 1'b1;
    wait_frames(bd + bdr + 3, 200, ok);
    #1;
    smp_valid_i = 1'b0;
    msg_valid_i = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: frames not finished got 0 required 1"); end
    n_tests++;
    if (strobe_q.size() - bs !== exp.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d strobes required %0d", strobe_q.size() - bs, exp.size());
    end
    for (int i = 0; i < exp.size() && bs + i < strobe_q.size(); i++) begin
      n_tests++;
      if (strobe_q[bs+i] !== exp[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %h required %h", i, strobe_q[bs+i], exp[i]); end
    end
  endtask

  task automatic test_busy();
    int bs = strobe_q.size(), bd = done_seen, bdr = drop_seen, bv = busy_viol;
    bit ok;
    @(posedge clk); #1;
    busy_i = 1'b1;
    send_sample(16'h5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (tx_data_rdy_o !== 1'b0 || tx_data_o !== 8'hA5) begin
        n_fail++; $display("FAIL busy_hold%0d: rdy=%b data=%h required 0 a5", i, tx_data_rdy_o, tx_data_o);
      end
    end
    @(posedge clk); #1 busy_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'hA5) begin
      n_fail++; $display("FAIL busy_release: rdy=%b data=%h required 1 a5", tx_data_rdy_o, tx_data_o);
    end
    wait_frames(bd + bdr + 1, 100, ok);
    n_tests++;
    if (!ok || strobe_q.size() - bs !== 3 || busy_viol !== bv) begin
      n_fail++; $display("FAIL busy_frame: done=%b strobes=%0d viol=%0d required 1 3 %0d", ok, strobe_q.size() - bs, busy_viol, bv);
    end
  endtask

  task automatic test_retry_recover();
    logic [7:0] exp[$] = '{8'hA5, 8'h12, 8'h12, 8'h12, 8'h34};
    int bs = strobe_q.size(), bd = done_seen, bdr = drop_seen;
    bit ok;
    err_byte  = 8'h12;
    err_limit = errs_total + 2;
    resp_mode = 1;
    send_sample(16'h1234);
    wait_frames(bd + bdr + 1, 100, ok);
    resp_mode = 0;
    n_tests++;
    if (!ok || strobe_q.size() - bs !== exp.size()) begin
      n_fail++; $display("FAIL retry_count: finished=%b strobes=%0d required 1 %0d", ok, strobe_q.size() - bs, exp.size());
    end
    for (int i = 0; i < exp.size() && bs + i < strobe_q.size(); i++) begin
      n_tests++;
      if (strobe_q[bs+i] !== exp[i]) begin n_fail++; $display("FAIL retry_byte%0d: got %h required %h", i, strobe_q[bs+i], exp[i]); end
    end
    n_tests++;
    if (done_seen - bd !== 1 || drop_seen - bdr !== 0) begin
      n_fail++; $display("FAIL retry_pulses: done %0d drop %0d required 1 0", done_seen - bd, drop_seen - bdr);
    end
  endtask

  task automatic test_drop(input int mode, input logic [7:0] exp_cnt, input int exp_gap);
    int bs = strobe_q.size(), bd = done_seen, bdr = drop_seen;
    bit ok;
    resp_mode = mode;
    send_sample(16'h1234);
    wait_frames(bd + bdr + 1, 300, ok);
    @(negedge clk);
    resp_mode = 0;
    n_tests++;
    if (!ok || strobe_q.size() - bs !== 4) begin
      n_fail++; $display("FAIL drop%0d_count: finished=%b strobes=%0d required 1 4", mode, ok, strobe_q.size() - bs);
    end
    for (int i = 0; i < 4 && bs + i < strobe_q.size(); i++) begin
      n_tests++;
      if (strobe_q[bs+i] !== 8'hA5) begin n_fail++; $display("FAIL drop%0d_byte%0d: got %h required a5", mode, i, strobe_q[bs+i]); end
    end
    for (int i = 1; i < 4 && bs + i < strobe_t.size(); i++) begin
      n_tests++;
      if (strobe_t[bs+i] - strobe_t[bs+i-1] !== exp_gap) begin
        n_fail++; $display("FAIL drop%0d_gap%0d: got %0d required %0d", mode, i, strobe_t[bs+i] - strobe_t[bs+i-1], exp_gap);
      end
    end
    n_tests++;
    if (drop_seen - bdr !== 1 || done_seen - bd !== 0 || drop_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL drop%0d_result: drop %0d done %0d cnt %0d required 1 0 %0d", mode, drop_seen - bdr, done_seen - bd, drop_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp[$] = '{8'hA5, 8'h9A, 8'hBC};
    int bs = strobe_q.size(), bd = done_seen, bdr = drop_seen;
    bit got, ok;
    resp_mode = 3;
    send_sample(16'h1234);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (strobe_q.size() > bs) begin got = 1'b1; break; end
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL midrst_strobe: got 0 required 1"); end
    @(posedge clk); #1 reset_ni = 1'b0;
    #1;
    n_tests++;
    if ({tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o, smp_ready_o, msg_ready_o} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: outputs=%b required all zero", {tx_data_rdy_o, tx_data_o, frame_done_o, frame_drop_o, drop_cnt_o});
    end
    resp_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset_ni = 1'b1;
    n_tests++;
    if (done_seen - bd !== 0 || drop_seen - bdr !== 0) begin
      n_fail++; $display("FAIL midrst_pulses: done %0d drop %0d required 0 0", done_seen - bd, drop_seen - bdr);
    end
    bs = strobe_q.size(); bd = done_seen; bdr = drop_seen;
    send_sample(16'h9ABC);
    wait_frames(bd + bdr + 1, 100, ok);
    n_tests++;
    if (!ok || strobe_q.size() - bs !== 3) begin
      n_fail++; $display("FAIL midrst_count: finished=%b strobes=%0d required 1 3", ok, strobe_q.size() - bs);
    end
    for (int i = 0; i < 3 && bs + i < strobe_q.size(); i++) begin
      n_tests++;
      if (strobe_q[bs+i] !== exp[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h required %h", i, strobe_q[bs+i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_round_robin();
    test_busy();
    test_retry_recover();
    test_drop(2, 8'd1, 3);
    test_drop(3, 8'd2, ACK_TO + 3);
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
